// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - shared RV32I decode constants, ALU op codes and decode FSM states
package friscv_pkg;

  localparam int ARCH = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SAR = 4'd7;
  localparam logic [3:0] ALU_SLR = 4'd8;

  typedef enum logic [1:0] {EMPTY, FULL, HALT} decode_state_t;

  function automatic logic [ARCH-1:0] zext_shamt(input logic [4:0] shamt);
    return {{(ARCH-5){1'b0}}, shamt};
  endfunction

endpackage

// File: rtl/alu_decode_imm_gen.sv
// rtl/alu_decode_imm_gen.sv - combinational I-type and U-type immediate extraction
module imm_gen
  import friscv_pkg::*;
(
  input  logic [31:0]     instr_in,
  output logic [ARCH-1:0] imm_i_out,
  output logic [ARCH-1:0] imm_u_out
);

  assign imm_i_out = {{(ARCH-12){instr_in[31]}}, instr_in[31:20]};
  assign imm_u_out = {instr_in[31:12], 12'b0};

endmodule

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - registered RV32I decode stage feeding the ALU (optional FRISCV_DECODE_ILLEGAL_EN halt)
module alu_decode
  import friscv_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [31:0]     instr_in,
  input  logic [ARCH-1:0] pc_in,
  input  logic [ARCH-1:0] rs1_data_in,
  input  logic [ARCH-1:0] rs2_data_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  output logic [3:0]      alu_ctrl_out,
  output logic [ARCH-1:0] alu_a_out,
  output logic [ARCH-1:0] alu_b_out,
  output logic [4:0]      rd_addr_out,
  output logic            rd_we_out,
  output logic            alu_valid_out,
`ifdef FRISCV_DECODE_ILLEGAL_EN
  output logic            illegal_out,
`endif
  input  logic            alu_ready_in
);

  decode_state_t   r_state;
  decode_state_t   w_state_nxt;
  logic [3:0]      r_ctrl;
  logic [ARCH-1:0] r_a;
  logic [ARCH-1:0] r_b;
  logic [4:0]      r_rd;
  logic            r_we;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [ARCH-1:0] w_imm_i;
  logic [ARCH-1:0] w_imm_u;
  logic [3:0]      w_ctrl;
  logic [ARCH-1:0] w_a;
  logic [ARCH-1:0] w_b;
  logic            w_illegal;
  logic            w_we;
  logic            w_accept;
  logic            w_drain;
  logic            w_halt_on_accept;

  assign w_opc = instr_in[6:0];
  assign w_f3  = instr_in[14:12];
  assign w_f7  = instr_in[31:25];
  assign w_rd  = instr_in[11:7];

  imm_gen u_imm_gen (
    .instr_in  (instr_in),
    .imm_i_out (w_imm_i),
    .imm_u_out (w_imm_u)
  );

  always_comb begin
    w_ctrl    = ALU_ADD;
    w_a       = '0;
    w_b       = '0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_a = rs1_data_in;
        w_b = rs2_data_in;
        case (w_f3)
          F3_ADD: begin
            w_ctrl    = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            w_illegal = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
          end
          F3_SLL: begin
            w_ctrl    = ALU_SLL;
            w_b       = zext_shamt(rs2_data_in[4:0]);
            w_illegal = (w_f7 != F7_ZERO);
          end
          F3_SLT: begin w_ctrl = ALU_SLT; w_illegal = (w_f7 != F7_ZERO); end
          F3_XOR: begin w_ctrl = ALU_XOR; w_illegal = (w_f7 != F7_ZERO); end
          F3_OR:  begin w_ctrl = ALU_OR;  w_illegal = (w_f7 != F7_ZERO); end
          F3_AND: begin w_ctrl = ALU_AND; w_illegal = (w_f7 != F7_ZERO); end
          F3_SR: begin
            w_ctrl    = (w_f7 == F7_ALT) ? ALU_SAR : ALU_SLR;
            w_b       = zext_shamt(rs2_data_in[4:0]);
            w_illegal = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_a = rs1_data_in;
        w_b = w_imm_i;
        case (w_f3)
          F3_ADD: w_ctrl = ALU_ADD;
          F3_SLT: w_ctrl = ALU_SLT;
          F3_XOR: w_ctrl = ALU_XOR;
          F3_OR:  w_ctrl = ALU_OR;
          F3_AND: w_ctrl = ALU_AND;
          F3_SLL: begin
            w_ctrl    = ALU_SLL;
            w_b       = zext_shamt(instr_in[24:20]);
            w_illegal = (w_f7 != F7_ZERO);
          end
          F3_SR: begin
            w_ctrl    = (w_f7 == F7_ALT) ? ALU_SAR : ALU_SLR;
            w_b       = zext_shamt(instr_in[24:20]);
            w_illegal = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LUI: w_b = w_imm_u;
      OPC_AUIPC: begin
        w_a = pc_in;
        w_b = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal words collapse to a harmless ADD 0,0 with no writeback
    if (w_illegal) begin
      w_ctrl = ALU_ADD;
      w_a    = '0;
      w_b    = '0;
    end
  end

  assign w_we = (w_rd != 5'd0) && !w_illegal;

  assign instr_ready_out = (r_state == EMPTY) || ((r_state == FULL) && alu_ready_in);
  assign w_accept        = instr_valid_in && instr_ready_out;
  assign w_drain         = (r_state == FULL) && alu_ready_in;

`ifdef FRISCV_DECODE_ILLEGAL_EN
  assign w_halt_on_accept = w_illegal;
`else
  assign w_halt_on_accept = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_state_nxt = w_halt_on_accept ? HALT : FULL;
      FULL: begin
        if (w_accept)     w_state_nxt = w_halt_on_accept ? HALT : FULL;
        else if (w_drain) w_state_nxt = EMPTY;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= EMPTY;
      r_ctrl  <= ALU_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ctrl <= w_ctrl;
        r_a    <= w_a;
        r_b    <= w_b;
        r_rd   <= w_rd;
        r_we   <= w_we;
      end
    end
  end

`ifdef FRISCV_DECODE_ILLEGAL_EN
  logic r_illegal;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_illegal <= 1'b0;
    else if (w_accept && w_illegal) r_illegal <= 1'b1;
  end

  assign illegal_out = r_illegal;
`endif

  assign alu_valid_out = (r_state == FULL);
  assign alu_ctrl_out  = r_ctrl;
  assign alu_a_out     = r_a;
  assign alu_b_out     = r_b;
  assign rd_addr_out   = r_rd;
  assign rd_we_out     = r_we;

endmodule

// File: tb/tb_alu_decode.sv
// tb/tb_alu_decode.sv - vector table and scoreboard bench for alu_decode (FRISCV_DECODE_ILLEGAL_EN aware)
module tb_alu_decode;
  import friscv_pkg::*;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ill;
    exp_t        exp;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] rs1_data_in = '0;
  logic [31:0] rs2_data_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        instr_ready_out;
  logic [3:0]  alu_ctrl_out;
  logic [31:0] alu_a_out;
  logic [31:0] alu_b_out;
  logic [4:0]  rd_addr_out;
  logic        rd_we_out;
  logic        alu_valid_out;
  logic        alu_ready_in = 1'b0;
`ifdef FRISCV_DECODE_ILLEGAL_EN
  logic        illegal_out;
`endif

  alu_decode dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .instr_in        (instr_in),
    .pc_in           (pc_in),
    .rs1_data_in     (rs1_data_in),
    .rs2_data_in     (rs2_data_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .alu_ctrl_out    (alu_ctrl_out),
    .alu_a_out       (alu_a_out),
    .alu_b_out       (alu_b_out),
    .rd_addr_out     (rd_addr_out),
    .rd_we_out       (rd_we_out),
    .alu_valid_out   (alu_valid_out),
`ifdef FRISCV_DECODE_ILLEGAL_EN
    .illegal_out     (illegal_out),
`endif
    .alu_ready_in    (alu_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic halted = 1'b0;
  vec_t vecs[$];
  vec_t ills[$];
  vec_t idle;

  function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2,
                              input logic [3:0] ctrl, input logic [31:0] a, b,
                              input logic [4:0] rd, input logic we);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.ill = 1'b0;
    v.exp = '{ctrl: ctrl, a: a, b: b, rd: rd, we: we};
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    chk("valid", 80'(alu_valid_out), 80'(sb.size() != 0));
    if (sb.size() != 0)
      chk("outputs", 80'({alu_ctrl_out, alu_a_out, alu_b_out, rd_addr_out, rd_we_out}), 80'(sb[0]));
`ifdef FRISCV_DECODE_ILLEGAL_EN
    chk("illegal", 80'(illegal_out), 80'(halted));
`endif
  endtask

  task automatic step(input logic v, input vec_t vc, input logic dr, output logic acc);
    logic exp_rdy;
    @(negedge clk_in);
    check_out();
    instr_valid_in = v;
    instr_in       = vc.instr;
    pc_in          = vc.pc;
    rs1_data_in    = vc.rs1;
    rs2_data_in    = vc.rs2;
    alu_ready_in   = dr;
    #1;
    exp_rdy = !halted && ((sb.size() == 0) || dr);
    chk("ready", 80'(instr_ready_out), 80'(exp_rdy));
    if (sb.size() != 0 && dr) void'(sb.pop_front());
    acc = v && exp_rdy;
    if (acc) begin
`ifdef FRISCV_DECODE_ILLEGAL_EN
      if (vc.ill) halted = 1'b1;
      else sb.push_back(vc.exp);
`else
      sb.push_back(vc.exp);
`endif
    end
  endtask

  task automatic reset_seq();
    @(negedge clk_in);
    rst_in = 1'b1;
    instr_valid_in = 1'b1;
    alu_ready_in = 1'b0;
    @(negedge clk_in);
    sb.delete();
    halted = 1'b0;
    chk("rst_valid", 80'(alu_valid_out), 80'(0));
    chk("rst_outputs", 80'({alu_ctrl_out, alu_a_out, alu_b_out, rd_addr_out, rd_we_out}),
        80'({ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0}));
`ifdef FRISCV_DECODE_ILLEGAL_EN
    chk("rst_illegal", 80'(illegal_out), 80'(0));
`endif
    rst_in = 1'b0;
    instr_valid_in = 1'b0;
    #1;
    chk("rst_ready", 80'(instr_ready_out), 80'(1));
  endtask

  task automatic run_table(input vec_t tbl[$]);
    foreach (tbl[i]) begin
      logic acc;
      logic gap;
      int   tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 40) begin
        gap = ($urandom_range(0, 3) == 0);
        step(!gap, tbl[i], ($urandom_range(0, 2) != 0), acc);
        tries++;
      end
      if (!acc) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: vector %0d not accepted, required within 40 cycles", i);
      end
    end
  endtask

  initial begin
    logic acc;
    idle = mk(32'h0, 32'h0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0);

    vecs.push_back(mk(32'hFFF10093, 32'h0,    32'd5,        32'd0,        ALU_ADD, 32'd5,        32'hFFFFFFFF, 5'd1,  1'b1));
    vecs.push_back(mk(32'h40208033, 32'h0,    32'd9,        32'd4,        ALU_SUB, 32'd9,        32'd4,        5'd0,  1'b0));
    vecs.push_back(mk(32'h40325193, 32'h0,    32'h80000000, 32'd0,        ALU_SAR, 32'h80000000, 32'd3,        5'd3,  1'b1));
    vecs.push_back(mk(32'h123452B7, 32'h40,   32'hDEADBEEF, 32'd0,        ALU_ADD, 32'd0,        32'h12345000, 5'd5,  1'b1));
    vecs.push_back(mk(32'hFFFFF317, 32'h1000, 32'hDEADBEEF, 32'd0,        ALU_ADD, 32'h1000,     32'hFFFFF000, 5'd6,  1'b1));
    vecs.push_back(mk(32'h009413B3, 32'h0,    32'd1,        32'hFFFFFFE5, ALU_SLL, 32'd1,        32'd5,        5'd7,  1'b1));
    vecs.push_back(mk(32'h00C5C533, 32'h0,    32'hF0F0F0F0, 32'h0FF00FF0, ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd10, 1'b1));
    vecs.push_back(mk(32'h7FF0E093, 32'h0,    32'h12,       32'd0,        ALU_OR,  32'h12,       32'h000007FF, 5'd1,  1'b1));
    vecs.push_back(mk(32'h8001F113, 32'h0,    32'h77,       32'd0,        ALU_AND, 32'h77,       32'hFFFFF800, 5'd2,  1'b1));
    vecs.push_back(mk(32'h0062A233, 32'h0,    32'hFFFFFFFE, 32'd3,        ALU_SLT, 32'hFFFFFFFE, 32'd3,        5'd4,  1'b1));
    vecs.push_back(mk(32'h00A4D433, 32'h0,    32'h80,       32'h3F,       ALU_SLR, 32'h80,       32'h1F,       5'd8,  1'b1));
    vecs.push_back(mk(32'h40A4D433, 32'h0,    32'h80,       32'h3F,       ALU_SAR, 32'h80,       32'h1F,       5'd8,  1'b1));
    vecs.push_back(mk(32'h01F11093, 32'h0,    32'd7,        32'd0,        ALU_SLL, 32'd7,        32'd31,       5'd1,  1'b1));
    vecs.push_back(mk(32'hFFF12093, 32'h0,    32'd7,        32'd0,        ALU_SLT, 32'd7,        32'hFFFFFFFF, 5'd1,  1'b1));
    vecs.push_back(mk(32'h01DF7FB3, 32'h0,    32'hFF00FF00, 32'h0F0F0F0F, ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 5'd31, 1'b1));
    vecs.push_back(mk(32'h00418133, 32'h0,    32'd100,      32'd23,       ALU_ADD, 32'd100,      32'd23,       5'd2,  1'b1));
    vecs.push_back(mk(32'h0F024193, 32'h0,    32'hAA,       32'd0,        ALU_XOR, 32'hAA,       32'hF0,       5'd3,  1'b1));
    vecs.push_back(mk(32'h40000093, 32'h0,    32'd1,        32'd0,        ALU_ADD, 32'd1,        32'h400,      5'd1,  1'b1));

    ills.push_back(mk(32'h0020B033, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0));
    ills.push_back(mk(32'h00002283, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 5'd5, 1'b0));
    ills.push_back(mk(32'h40111093, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0));
    ills.push_back(mk(32'h022080B3, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0));
    ills.push_back(mk(32'h403160B3, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0));
    foreach (ills[i]) ills[i].ill = 1'b1;

    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk("init_valid", 80'(alu_valid_out), 80'(0));
    chk("init_outputs", 80'({alu_ctrl_out, alu_a_out, alu_b_out, rd_addr_out, rd_we_out}),
        80'({ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0}));
    #1;
    chk("init_ready", 80'(instr_ready_out), 80'(1));

    run_table(vecs);
    repeat (2) step(1'b0, idle, 1'b1, acc);

    // Stall two cycles with a new instruction waiting, then release
    step(1'b1, vecs[0], 1'b1, acc);
    step(1'b1, vecs[1], 1'b0, acc);
    step(1'b1, vecs[1], 1'b0, acc);
    step(1'b1, vecs[1], 1'b1, acc);
    chk("bp_accept_on_release", 80'(acc), 80'(1));
    step(1'b0, idle, 1'b1, acc);
    step(1'b0, idle, 1'b1, acc);

`ifdef FRISCV_DECODE_ILLEGAL_EN
    step(1'b1, vecs[2], 1'b0, acc);
    step(1'b1, ills[0], 1'b1, acc);
    repeat (3) step(1'b1, vecs[3], 1'b1, acc);
    chk("halt_state_valid", 80'(alu_valid_out), 80'(0));
    reset_seq();
`else
    run_table(ills);
    repeat (2) step(1'b0, idle, 1'b1, acc);
`endif

    // Reset while holding an undrained instruction
    step(1'b1, vecs[4], 1'b0, acc);
    step(1'b0, idle, 1'b0, acc);
    reset_seq();
    run_table(vecs);
    repeat (2) step(1'b0, idle, 1'b1, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
Name: alu_decode

Overview:
- Registered RV32I decode stage; it is the producer end of the ALU control interface.
- Turns an instruction word plus register-file read data into the 4-bit ALU control code, the A/B operands and the writeback target.
- Sits between register read and the ALU. One-entry pipeline register with valid/ready handshakes on both sides.

Parameters:
- ARCH, 32 (from friscv_pkg): datapath width. The block supports only 32.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction word.
- pc_in  input  ARCH  PC of instr_in.
- rs1_data_in  input  ARCH  rs1 read data.
- rs2_data_in  input  ARCH  rs2 read data.
- instr_valid_in  input  1  upstream valid.
- instr_ready_out  output  1  stage can accept.
- alu_ctrl_out  output  4  ALU op code (friscv_pkg: AND/OR/XOR/ADD/SUB/SLT/SLL/SAR/SLR).
- alu_a_out  output  ARCH  operand A.
- alu_b_out  output  ARCH  operand B.
- rd_addr_out  output  5  destination register.
- rd_we_out  output  1  writeback enable.
- alu_valid_out  output  1  outputs hold a decoded instruction.
- alu_ready_in  input  1  downstream accepts.

Behaviour:
- Reset (rst_in=1 at a clk_in edge):
  - alu_valid_out=0, rd_we_out=0, rd_addr_out=0, alu_a_out=0, alu_b_out=0, alu_ctrl_out=ADD.
  - FSM goes to EMPTY.
  - Reset overrides any transfer in flight. A held instruction is discarded.
- Handshake:
  - instr_ready_out = (state==EMPTY) or (state==FULL and alu_ready_in). It is combinational.
  - Accept occurs when instr_valid_in and instr_ready_out. Output is drain when alu_valid_out and alu_ready_in.
  - Latency 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
  - Throughput 1 instruction/cycle.
  - Outputs are stable while alu_valid_out=1 and alu_ready_in=0.
- FSM:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on simultaneous accept and drain (register reloads).
  - FULL -> EMPTY on drain without accept.
  - FULL holds otherwise.
  - alu_valid_out = (state==FULL).
- Decode (op = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP (0110011), A=rs1, B=rs2:
    - f3 000: ADD, or SUB if f7=0100000.
    - 001: SLL. 010: SLT. 100: XOR. 110: OR. 111: AND.
    - 101: SLR, or SAR if f7=0100000.
    - For shifts, B = zero-extended rs2[4:0].
  - OP-IMM (0010011), A=rs1, B=sign-extended instr[31:20]:
    - Same f3 map as OP, except f3 000 is always ADD.
    - Shifts use B = zero-extended instr[24:20]. f7 must be 0000000, or 0100000 for SRAI only.
  - LUI (0110111): ADD, A=0, B={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, A=pc_in, B={instr[31:12],12'b0}.
  - rd_addr_out = instr[11:7]. rd_we_out=1 unless rd=0 or the instruction is illegal.
- Illegal instructions:
  - Any other opcode.
  - f3=011 (SLTU/SLTIU; the ALU has no unsigned compare).
  - A non-zero f7 where f7 must be zero, or an f7 other than 0000000/0100000 on OP.

Optional Feature:
- Macro: FRISCV_DECODE_ILLEGAL_EN.
- Enabled:
  - Adds output port illegal_out (1 bit) and FSM state HALT.
  - Accepting an illegal instruction sets state HALT, illegal_out=1, alu_valid_out=0, instr_ready_out=0.
  - HALT persists until rst_in. Reset clears illegal_out to 0.
- Disabled:
  - An illegal instruction decodes as a NOP: ADD, A=0, B=0, rd_we_out=0, alu_valid_out=1.
  - It flows normally through the stage.

Decomposition:
- friscv_pkg gains:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - funct3/funct7 constants;
  - the decode_state_t enum {EMPTY, FULL, HALT}.
- One sub-module, imm_gen: combinational; instr in, I-type and U-type immediates out.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1=5, valid=1, ready=1 -> next cycle: ctrl=ADD, a=5, b=0xFFFFFFFF, rd=1, we=1, alu_valid_out=1.
- SUB x0,x1,x2 (0x40208033), rs1=9, rs2=4 -> ctrl=SUB, a=9, b=4, rd_we_out=0.
- SRAI x3,x4,3 (0x40325193), rs1=0x80000000 -> ctrl=SAR, b=3, rd=3.
- Backpressure: hold alu_ready_in=0 for 2 cycles with FULL and a new instr valid:
  - -> outputs unchanged and instr_ready_out=0 during stall;
  - -> new instr appears 1 cycle after ready rises.
- SLTU x0,x1,x2 (0x0020B033):
  - -> with macro: illegal_out=1, HALT, instr_ready_out=0 until reset;
  - -> without macro: ADD, a=0, b=0, we=0.
- Assert rst_in while FULL with alu_ready_in=0 -> next cycle alu_valid_out=0, outputs at reset values, instr_ready_out=1.
